// File: rtl/phy_regfile_read_stage.sv
// Physical register file and operand-read stage.
// Holds the physical register array plus a per-register ready bit, reads two
// source operands per renamed instruction, clears the destination's ready bit
// on allocation, and registers the result into a one-entry output stage with
// a valid/ready handshake. The held entry snoops writebacks while stalled.
// Optional feature macro: PHY_REGFILE_BYPASS_EN (same-cycle writeback forward
// into the operand read; when undefined a matching writeback stalls one cycle).

`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef GENERATED_IMMEDIATE_WIDTH
`define GENERATED_IMMEDIATE_WIDTH 32
`endif

package phy_regfile_pkg;
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [3:0] alu_op;
    } control_t;
endpackage

module phy_regfile_read_stage
    import phy_regfile_pkg::*;
#(
    parameter int PHY_REG_W = `PHYSICAL_REG_NUM_WIDTH,
    parameter int DATA_W    = 32,
    parameter int PC_W      = `INST_ADDR_WIDTH,
    parameter int IMM_W     = `GENERATED_IMMEDIATE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  control_t             in_control,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PHY_REG_W-1:0] in_src1,
    input  logic [PHY_REG_W-1:0] in_src2,
    input  logic [PHY_REG_W-1:0] in_dst,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 wb_valid,
    input  logic [PHY_REG_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output control_t             out_control,
    output logic [PC_W-1:0]      out_pc,
    output logic [IMM_W-1:0]     out_imm,
    output logic [PHY_REG_W-1:0] out_dst,
    output logic [PHY_REG_W-1:0] out_src1,
    output logic [PHY_REG_W-1:0] out_src2,
    output logic [DATA_W-1:0]    out_data1,
    output logic [DATA_W-1:0]    out_data2,
    output logic                 out_rdy1,
    output logic                 out_rdy2
);

    localparam int                   DEPTH     = 1 << PHY_REG_W;
    localparam logic [PHY_REG_W-1:0] REG_ZERO  = {PHY_REG_W{1'b0}};
    localparam logic [DATA_W-1:0]    DATA_ZERO = {DATA_W{1'b0}};

    typedef struct packed {
        control_t             ctrl;
        logic [PC_W-1:0]      pc;
        logic [IMM_W-1:0]     imm;
        logic [PHY_REG_W-1:0] dst;
        logic [PHY_REG_W-1:0] src1;
        logic [PHY_REG_W-1:0] src2;
        logic [DATA_W-1:0]    data1;
        logic [DATA_W-1:0]    data2;
        logic                 rdy1;
        logic                 rdy2;
    } entry_t;

    // p0 is hardwired; a forwarded writeback beats the array; otherwise read the array.
    function automatic logic [DATA_W:0] read_operand(
        input logic [PHY_REG_W-1:0] src,
        input logic [DATA_W-1:0]    arr_data,
        input logic                 arr_rdy,
        input logic                 fwd,
        input logic [DATA_W-1:0]    fwd_data
    );
        logic [DATA_W:0] res;
        if (src == REG_ZERO) begin
            res = {1'b1, DATA_ZERO};
        end else if (fwd) begin
            res = {1'b1, fwd_data};
        end else begin
            res = {arr_rdy, arr_data};
        end
        return res;
    endfunction

    logic [DATA_W-1:0] regs_q  [DEPTH];
    logic [DATA_W-1:0] regs_d  [DEPTH];
    logic [DEPTH-1:0]  ready_q;
    logic [DEPTH-1:0]  ready_d;
    entry_t            entry_q;
    entry_t            entry_d;
    logic              out_valid_q;
    logic              out_valid_d;

    logic              wb_en_s;
    logic              wb_hit1_s;
    logic              wb_hit2_s;
    logic              fwd1_s;
    logic              fwd2_s;
    logic              byp_stall_s;
    logic              in_ready_s;
    logic              fire_s;
    logic              alloc_s;
    logic              snoop1_s;
    logic              snoop2_s;
    logic [DATA_W:0]   op1_s;
    logic [DATA_W:0]   op2_s;

    // Accept control: writeback matches against incoming sources, stall and fire.
    always_comb begin
        wb_en_s   = wb_valid && (wb_reg != REG_ZERO);
        wb_hit1_s = wb_en_s && (wb_reg == in_src1);
        wb_hit2_s = wb_en_s && (wb_reg == in_src2);
`ifdef PHY_REGFILE_BYPASS_EN
        fwd1_s      = wb_hit1_s;
        fwd2_s      = wb_hit2_s;
        byp_stall_s = 1'b0;
`else
        // Without forwarding, wait one cycle so the array holds the written value.
        fwd1_s      = 1'b0;
        fwd2_s      = 1'b0;
        byp_stall_s = in_valid && (wb_hit1_s || wb_hit2_s);
`endif
        in_ready_s = !flush && (!out_valid_q || out_ready) && !byp_stall_s;
        fire_s     = in_valid && in_ready_s;
        alloc_s    = fire_s && in_control.reg_write && (in_dst != REG_ZERO);
        snoop1_s   = wb_en_s && (wb_reg == entry_q.src1) && !entry_q.rdy1;
        snoop2_s   = wb_en_s && (wb_reg == entry_q.src2) && !entry_q.rdy2;
        op1_s      = read_operand(in_src1, regs_q[in_src1], ready_q[in_src1], fwd1_s, wb_data);
        op2_s      = read_operand(in_src2, regs_q[in_src2], ready_q[in_src2], fwd2_s, wb_data);
    end

    // Next array/ready state: writeback sets ready, allocation clears it and wins a tie.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i]  = (wb_en_s && (wb_reg == PHY_REG_W'(i))) ? wb_data : regs_q[i];
            ready_d[i] = (alloc_s && (in_dst == PHY_REG_W'(i))) ? 1'b0 :
                         (wb_en_s && (wb_reg == PHY_REG_W'(i))) ? 1'b1 : ready_q[i];
        end
        regs_d[0]  = DATA_ZERO;
        ready_d[0] = 1'b1;
    end

    // Next output-stage state: flush, load on fire, drain on dequeue, snoop while held.
    always_comb begin
        out_valid_d = out_valid_q;
        entry_d     = entry_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire_s) begin
            out_valid_d   = 1'b1;
            entry_d.ctrl  = in_control;
            entry_d.pc    = in_pc;
            entry_d.imm   = in_imm;
            entry_d.dst   = in_dst;
            entry_d.src1  = in_src1;
            entry_d.src2  = in_src2;
            entry_d.rdy1  = op1_s[DATA_W];
            entry_d.data1 = op1_s[DATA_W-1:0];
            entry_d.rdy2  = op2_s[DATA_W];
            entry_d.data2 = op2_s[DATA_W-1:0];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            entry_d.data1 = snoop1_s ? wb_data : entry_q.data1;
            entry_d.rdy1  = snoop1_s ? 1'b1    : entry_q.rdy1;
            entry_d.data2 = snoop2_s ? wb_data : entry_q.data2;
            entry_d.rdy2  = snoop2_s ? 1'b1    : entry_q.rdy2;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset empties the output stage and marks every register ready at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_ZERO;
            end
            ready_q     <= {DEPTH{1'b1}};
            entry_q     <= entry_t'({$bits(entry_t){1'b0}});
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            ready_q     <= ready_d;
            entry_q     <= entry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_q;
    assign out_control = entry_q.ctrl;
    assign out_pc      = entry_q.pc;
    assign out_imm     = entry_q.imm;
    assign out_dst     = entry_q.dst;
    assign out_src1    = entry_q.src1;
    assign out_src2    = entry_q.src2;
    assign out_data1   = entry_q.data1;
    assign out_data2   = entry_q.data2;
    assign out_rdy1    = entry_q.rdy1;
    assign out_rdy2    = entry_q.rdy2;

endmodule

// File: tb/tb_phy_regfile_read_stage.sv
// Scoreboard bench for phy_regfile_read_stage: accepted instructions push an
// expected output entry; a negedge monitor pops and compares on each dequeue.
module tb_phy_regfile_read_stage;
    import phy_regfile_pkg::*;

    localparam int PW = 6;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 32;
`ifdef PHY_REGFILE_BYPASS_EN
    localparam int BYP_WAITS = 0;
`else
    localparam int BYP_WAITS = 1;
`endif

    typedef struct packed {
        control_t       ctrl;
        logic [AW-1:0]  pc;
        logic [IW-1:0]  imm;
        logic [PW-1:0]  dst;
        logic [PW-1:0]  src1;
        logic [PW-1:0]  src2;
        logic [DW-1:0]  d1;
        logic [DW-1:0]  d2;
        logic           r1;
        logic           r2;
    } exp_t;

    logic          clk;
    logic          rst_n;
    control_t      in_control;
    logic [AW-1:0] in_pc;
    logic [PW-1:0] in_src1, in_src2, in_dst;
    logic [IW-1:0] in_imm;
    logic          in_valid, in_ready;
    logic          wb_valid;
    logic [PW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid, out_ready;
    control_t      out_control;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_imm;
    logic [PW-1:0] out_dst, out_src1, out_src2;
    logic [DW-1:0] out_data1, out_data2;
    logic          out_rdy1, out_rdy2;

    exp_t     exp_q[$];
    exp_t     mon_exp, mon_act;
    int       n_checks = 0;
    int       n_fail   = 0;
    int       waits;
    control_t c_rw, c_nw;

    phy_regfile_read_stage #(.PHY_REG_W(PW), .DATA_W(DW), .PC_W(AW), .IMM_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .in_control(in_control), .in_pc(in_pc),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_imm(in_imm),
        .in_valid(in_valid), .in_ready(in_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_control(out_control), .out_pc(out_pc), .out_imm(out_imm), .out_dst(out_dst),
        .out_src1(out_src1), .out_src2(out_src2), .out_data1(out_data1), .out_data2(out_data2),
        .out_rdy1(out_rdy1), .out_rdy2(out_rdy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every dequeue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {224'd0, out_pc}, 256'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_act = {out_control, out_pc, out_imm, out_dst, out_src1, out_src2,
                           out_data1, out_data2, out_rdy1, out_rdy2};
                check($sformatf("entry_pc_%0h", mon_exp.pc), {100'd0, mon_act}, {100'd0, mon_exp});
            end
        end
    end

    // Present one instruction from just after a rising edge until accepted (bounded).
    // The optional writeback is driven only during the first cycle.
    task automatic issue(input control_t c, input logic [AW-1:0] pc,
                         input logic [PW-1:0] s1, input logic [PW-1:0] s2,
                         input logic [PW-1:0] d, input logic [IW-1:0] imm,
                         input logic wbv, input logic [PW-1:0] wbr, input logic [DW-1:0] wbd,
                         input logic push, input logic [DW-1:0] e_d1, input logic e_r1,
                         input logic [DW-1:0] e_d2, input logic e_r2, output int w);
        exp_t e;
        bit   done;
        done = 1'b0;
        w = 0;
        in_control = c; in_pc = pc; in_src1 = s1; in_src2 = s2; in_dst = d; in_imm = imm;
        in_valid = 1'b1;
        wb_valid = wbv; wb_reg = wbr; wb_data = wbd;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (push) begin
                    e = '{ctrl: c, pc: pc, imm: imm, dst: d, src1: s1, src2: s2,
                          d1: e_d1, d2: e_d2, r1: e_r1, r2: e_r2};
                    exp_q.push_back(e);
                end
            end else begin
                w++;
            end
            @(posedge clk); #1;
            wb_valid = 1'b0;
        end
        in_valid = 1'b0;
        if (!done) check("issue_timeout", 256'd0, 256'd1);
    endtask

    task automatic wb_pulse(input logic [PW-1:0] r, input logic [DW-1:0] d);
        wb_valid = 1'b1; wb_reg = r; wb_data = d;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    initial begin
        c_rw = 8'h00; c_rw.reg_write = 1'b1; c_rw.alu_op = 4'h2;
        c_nw = 8'h00; c_nw.mem_read  = 1'b1; c_nw.alu_op = 4'h5;
        rst_n = 1'b0; in_control = 8'h00; in_pc = '0; in_src1 = '0; in_src2 = '0;
        in_dst = '0; in_imm = '0; in_valid = 1'b0; wb_valid = 1'b0; wb_reg = '0;
        wb_data = '0; flush = 1'b0; out_ready = 1'b1;

        #12;
        check("rst_out_valid", {255'd0, out_valid}, 256'd0);
        check("rst_out_pc", {224'd0, out_pc}, 256'd0);
        check("rst_out_data_rdy", {190'd0, out_data1, out_data2, out_rdy1, out_rdy2}, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", {255'd0, in_ready}, 256'd1);

        // Allocate p5 with src1=3, src2=0; then p5 reads not ready.
        issue(c_rw, 32'h100, 6'd3, 6'd0, 6'd5, 32'h11, 1'b0, 6'd0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, waits);
        check("t1_wait", waits, 256'd0);
        issue(c_nw, 32'h104, 6'd5, 6'd3, 6'd6, 32'h22, 1'b0, 6'd0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, waits);
        check("t1b_wait", waits, 256'd0);

        // Writeback p5, then read it the following cycle.
        wb_pulse(6'd5, 32'hDEAD);
        issue(c_nw, 32'h108, 6'd5, 6'd0, 6'd0, 32'h33, 1'b0, 6'd0, 32'h0, 1'b1, 32'hDEAD, 1'b1, 32'h0, 1'b1, waits);
        check("t2_wait", waits, 256'd0);

        // Same-cycle writeback to src2: forwarded, or one bubble then array read.
        issue(c_nw, 32'h10C, 6'd0, 6'd7, 6'd0, 32'h44, 1'b1, 6'd7, 32'h1234, 1'b1, 32'h0, 1'b1, 32'h1234, 1'b1, waits);
        check("t3_wait", waits, BYP_WAITS);

        // Held entry with src1=9 not ready snoops a writeback.
        issue(c_rw, 32'h110, 6'd0, 6'd0, 6'd9, 32'h55, 1'b0, 6'd0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, waits);
        issue(c_nw, 32'h114, 6'd9, 6'd0, 6'd0, 32'h66, 1'b0, 6'd0, 32'h0, 1'b1, 32'h55, 1'b1, 32'h0, 1'b1, waits);
        check("t4_wait", waits, 256'd0);
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_held_rdy1", {254'd0, out_valid, out_rdy1}, 256'd2);
        check("t4_in_ready_held", {255'd0, in_ready}, 256'd0);
        wb_pulse(6'd9, 32'h55);
        @(negedge clk);
        check("t4_snoop", {222'd0, out_rdy1, out_data1, in_ready}, {222'd0, 1'b1, 32'h55, 1'b0});
        check("t4_stable_pc", {224'd0, out_pc}, 256'h114);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_in_ready_release", {255'd0, in_ready}, 256'd1);
        @(posedge clk); #1;

        // Same-cycle allocation and writeback of p4: array written, ready stays 0.
        issue(c_rw, 32'h118, 6'd0, 6'd0, 6'd4, 32'h77, 1'b1, 6'd4, 32'h77, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, waits);
        issue(c_nw, 32'h11C, 6'd4, 6'd4, 6'd0, 32'h88, 1'b0, 6'd0, 32'h0, 1'b1, 32'h77, 1'b0, 32'h77, 1'b0, waits);
        check("t5_wait", waits, 256'd0);
        @(negedge clk);
        @(posedge clk); #1;

        // Flush with a held entry and a presented instruction; writeback to p0 ignored.
        out_ready = 1'b0;
        issue(c_nw, 32'h120, 6'd0, 6'd0, 6'd0, 32'h99, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, waits);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h124; in_src1 = 6'd0; in_src2 = 6'd0;
        wb_valid = 1'b1; wb_reg = 6'd0; wb_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t6_in_ready_flush", {254'd0, out_valid, in_ready}, 256'd2);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("t6_out_valid_after_flush", {255'd0, out_valid}, 256'd0);
        @(posedge clk); #1;
        issue(c_nw, 32'h128, 6'd0, 6'd0, 6'd0, 32'hAA, 1'b0, 6'd0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, waits);
        @(negedge clk);
        @(posedge clk); #1;

        // Reset asserted while an entry is held drops it at once and restores the array.
        out_ready = 1'b0;
        issue(c_rw, 32'h12C, 6'd0, 6'd0, 6'd10, 32'hBB, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, waits);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_reset", {223'd0, out_valid, out_pc}, 256'd0);
        #3 rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        issue(c_nw, 32'h130, 6'd10, 6'd4, 6'd0, 32'hCC, 1'b0, 6'd0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, waits);
        check("t7_wait", waits, 256'd0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
